// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: FSM states, size/access encodings and helpers for the load/store unit
package load_store_unit_pkg;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE_LO = 3'd1,
    S_CAPT_LO  = 3'd2,
    S_ISSUE_HI = 3'd3,
    S_CAPT_HI  = 3'd4,
    S_DONE     = 3'd5
  } state_e;
  localparam logic SZ_BYTE   = 1'b0;
  localparam logic SZ_HALF   = 1'b1;
  localparam logic ACC_LOAD  = 1'b0;
  localparam logic ACC_STORE = 1'b1;
  function automatic logic is_issue(input state_e s);
    return s == S_ISSUE_LO || s == S_ISSUE_HI;
  endfunction
endpackage

// File: rtl/load_store_unit.sv
// load_store_unit: nRisc data-memory initiator, splits halfwords into two little-endian byte accesses
//  clk_i/rst_ni         clock, asynchronous active-low reset
//  req_*_i / req_ready_o one request at a time, accepted on valid&&ready
//  resp_valid_o/rdata_o one-cycle completion pulse with load data (0 for stores)
//  mem_*                byte-wide memory port; read sampled at posedge, write at negedge
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_write_i,
  input  logic                req_half_i,
  input  logic                req_signed_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [2*DATA_W-1:0] req_wdata_i,
  output logic                resp_valid_o,
  output logic [2*DATA_W-1:0] resp_rdata_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);
  state_e state_q, state_d;
  logic wr_q, half_q, sgn_q, wr_d, half_d, sgn_d, accept;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2*DATA_W-1:0] wdata_q, wdata_d, resp_d;
  logic [DATA_W-1:0] lo_q;
  assign req_ready_o = state_q == S_IDLE;
  assign accept = req_ready_o && req_valid_i;
  assign wr_d    = accept ? req_write_i  : wr_q;
  assign half_d  = accept ? req_half_i   : half_q;
  assign sgn_d   = accept ? req_signed_i : sgn_q;
  assign addr_d  = accept ? req_addr_i   : addr_q;
  assign wdata_d = accept ? req_wdata_i  : wdata_q;
  always_comb begin
    state_d = accept ? S_ISSUE_LO
            : state_q == S_ISSUE_LO ? (wr_q == ACC_STORE ? (half_q == SZ_HALF ? S_ISSUE_HI : S_DONE) : S_CAPT_LO)
            : state_q == S_CAPT_LO  ? (half_q == SZ_HALF ? S_ISSUE_HI : S_DONE)
            : state_q == S_ISSUE_HI ? (wr_q == ACC_STORE ? S_DONE : S_CAPT_HI)
            : state_q == S_CAPT_HI  ? S_DONE
            : S_IDLE;
  end
  // DONE is entered from the capture of the last byte, so mem_rdata_i holds that byte here
  assign resp_d = wr_q == ACC_STORE ? '0
                : half_q == SZ_BYTE ? {{DATA_W{sgn_q & mem_rdata_i[DATA_W-1]}}, mem_rdata_i}
                : {mem_rdata_i, lo_q};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      half_q       <= 1'b0;
      sgn_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      half_q       <= half_d;
      sgn_q        <= sgn_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lo_q         <= state_q == S_CAPT_LO ? mem_rdata_i : lo_q;
      resp_valid_o <= state_d == S_DONE;
      resp_rdata_o <= state_d == S_DONE ? resp_d : resp_rdata_o;
      mem_addr_o   <= state_d == S_ISSUE_HI ? addr_q + ADDR_W'(1) : addr_d;
      mem_wdata_o  <= state_d == S_ISSUE_HI ? wdata_q[2*DATA_W-1:DATA_W] : wdata_d[DATA_W-1:0];
      mem_read_o   <= is_issue(state_d) && wr_d == ACC_LOAD;
      mem_write_o  <= is_issue(state_d) && wr_d == ACC_STORE;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench with a 256x8 memory model
module tb_load_store_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, req_half = 1'b0, req_signed = 1'b0;
  logic [7:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic req_ready, resp_valid, mem_read, mem_write;
  logic [15:0] resp_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] mem [256];
  int total = 0, passed = 0, resp_cnt = 0, both_cnt = 0;
  always #5 clk = ~clk;
  load_store_unit #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_half_i(req_half), .req_signed_i(req_signed),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_rdata_i(mem_rdata)
  );
  initial mem_rdata = '0;
  always @(posedge clk) if (mem_read) mem_rdata <= mem[mem_addr];
  always @(negedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
  always @(negedge clk) begin
    if (resp_valid) resp_cnt++;
    if (mem_read && mem_write) both_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask
  task automatic do_req(input string tag, input logic w, input logic h, input logic s,
                        input logic [7:0] a, input logic [15:0] d, input int lat_e, input logic [15:0] rd_e);
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_half = h; req_signed = s; req_addr = a; req_wdata = d;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 12);
    chk({tag, "_lat"}, 32'(lat), 32'(lat_e));
    chk({tag, "_rdata"}, 32'(resp_rdata), 32'(rd_e));
    @(negedge clk);
  endtask
  initial begin
    int rc;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #2;
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    do_req("t1_sb", 1'b1, 1'b0, 1'b0, 8'h10, 16'h00A5, 2, 16'h0000);
    chk("t1_mem10", 32'(mem[8'h10]), 32'h A5);
    do_req("t1_lb", 1'b0, 1'b0, 1'b0, 8'h10, 16'hFFFF, 3, 16'h00A5);
    do_req("t2_sh", 1'b1, 1'b1, 1'b0, 8'h20, 16'hBEEF, 3, 16'h0000);
    chk("t2_mem20", 32'(mem[8'h20]), 32'hEF);
    chk("t2_mem21", 32'(mem[8'h21]), 32'hBE);
    do_req("t2_lh", 1'b0, 1'b1, 1'b0, 8'h20, 16'h0000, 5, 16'hBEEF);
    do_req("t3_sb", 1'b1, 1'b0, 1'b0, 8'h80, 16'h1180, 2, 16'h0000);
    do_req("t3_lbs", 1'b0, 1'b0, 1'b1, 8'h80, 16'h0000, 3, 16'hFF80);
    do_req("t3_lbu", 1'b0, 1'b0, 1'b0, 8'h80, 16'h0000, 3, 16'h0080);
    do_req("t3_lbs_pos", 1'b0, 1'b0, 1'b1, 8'h21, 16'h0000, 3, 16'hFFBE);
    do_req("t3_lbs_lo", 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 3, 16'h0000);
    do_req("t4_sh", 1'b1, 1'b1, 1'b0, 8'hFF, 16'h1234, 3, 16'h0000);
    chk("t4_memFF", 32'(mem[8'hFF]), 32'h34);
    chk("t4_mem00", 32'(mem[8'h00]), 32'h12);
    do_req("t4_lh", 1'b0, 1'b1, 1'b0, 8'hFF, 16'h0000, 5, 16'h1234);
    // held valid with changing fields while busy
    rc = resp_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_half = 1'b1; req_addr = 8'h40; req_wdata = 16'hCAFE;
    @(posedge clk);
    for (int i = 1; i <= 3; i++) begin
      #1 req_addr = 8'h50 + 8'(i); req_wdata = 16'h1111 * 16'(i); req_half = 1'b0;
      @(negedge clk);
      chk($sformatf("t5_ready_c%0d", i), 32'(req_ready), 32'd0);
      chk($sformatf("t5_resp_c%0d", i), 32'(resp_valid), (i == 3) ? 32'd1 : 32'd0);
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("t5_ready_after", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("t5_resp_cnt", 32'(resp_cnt - rc), 32'd1);
    chk("t5_mem40", 32'(mem[8'h40]), 32'hFE);
    chk("t5_mem41", 32'(mem[8'h41]), 32'hCA);
    chk("t5_mem51", 32'(mem[8'h51]), 32'h00);
    chk("t5_mem53", 32'(mem[8'h53]), 32'h00);
    // reset during the high byte of a halfword store
    mem[8'h61] = 8'h55;
    rc = resp_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_half = 1'b1; req_signed = 1'b0; req_addr = 8'h60; req_wdata = 16'h7788;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 chk("t6_in_issue_hi", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1 chk("t6_write_drop", 32'(mem_write), 32'd0);
    chk("t6_read_drop", 32'(mem_read), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ready", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("t6_mem60", 32'(mem[8'h60]), 32'h88);
    chk("t6_mem61", 32'(mem[8'h61]), 32'h55);
    chk("t6_no_resp", 32'(resp_cnt - rc), 32'd0);
    do_req("t6_lh_after", 1'b0, 1'b1, 1'b0, 8'h60, 16'h0000, 5, 16'h5588);
    chk("strobe_excl", 32'(both_cnt), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
